// File: rtl/chaser_ctrl.sv
// chaser_ctrl -- upstream control stage for the dual-pattern LED chaser.
//
// Conditions the two raw push-buttons into latched run/speed levels
// (synchronise -> sampled debounce -> one-pulse -> toggle) and generates the
// two single-cycle step strobes that advance the 1-LED and 3-LED patterns.
// Single clock domain; the ticks are clock enables for downstream logic.
//
// Parameters:
//   DB_DIV  debounce sample strobe every 2^DB_DIV clk cycles
//   DB_LEN  consecutive equal samples needed to change a debounced level (>=2)
//   FAST_W  fast tick period = 2^FAST_W cycles
//   SLOW_W  slow tick period = 2^SLOW_W cycles (SLOW_W > FAST_W)
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   btn_en     raw asynchronous bouncy enable button (1 = pressed)
//   btn_speed  raw asynchronous bouncy speed button (1 = pressed)
//   en         latched run enable, toggles once per debounced press
//   speed      latched speed select, toggles once per debounced press
//   tick_1     one-cycle step strobe for the 1-LED pattern
//   tick_3     one-cycle step strobe for the 3-LED pattern
//
// Optional build macro:
//   TICK_GATE_EN  when defined, tick_1/tick_3 are held at 0 while en = 0.
//                 The tick counter keeps running so the phase survives a
//                 pause/resume. When undefined, ticks run regardless of en.

module chaser_ctrl #(
  parameter int DB_DIV = 16,
  parameter int DB_LEN = 4,
  parameter int FAST_W = 23,
  parameter int SLOW_W = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_en,
  input  logic btn_speed,
  output logic en,
  output logic speed,
  output logic tick_1,
  output logic tick_3
);

  // New debounced level from the sample window: all-ones sets, all-zeros
  // clears, any mixture holds the current level.
  function automatic logic db_level(input logic [DB_LEN-1:0] win,
                                    input logic              cur);
    if (&win)
      return 1'b1;
    else if (~|win)
      return 1'b0;
    else
      return cur;
  endfunction

  logic              sync_en_p0, sync_en_p1;
  logic              sync_sp_p0, sync_sp_p1;
  logic [DB_DIV-1:0] div_cnt;
  logic              samp;
  logic [DB_LEN-1:0] win_en_p0, win_sp_p0;
  logic              db_en_p1, db_sp_p1;
  logic              db_en_p2, db_sp_p2;
  logic              press_en, press_speed;
  logic [SLOW_W-1:0] cnt;
  logic              f, s;
  logic              tick_1_p0, tick_3_p0;

  // Stage: two-flop synchronisers on the raw buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_en_p0 <= 1'b0;
      sync_en_p1 <= 1'b0;
      sync_sp_p0 <= 1'b0;
      sync_sp_p1 <= 1'b0;
    end else begin
      sync_en_p0 <= btn_en;
      sync_en_p1 <= sync_en_p0;
      sync_sp_p0 <= btn_speed;
      sync_sp_p1 <= sync_sp_p0;
    end
  end

  // Stage: free-running sample divider; strobe on the all-ones count
  always_ff @(posedge clk) begin
    if (rst)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + DB_DIV'(1);
  end

  assign samp = &div_cnt;

  // Stage: sample shift registers, advanced only on the sample strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      win_en_p0 <= '0;
      win_sp_p0 <= '0;
    end else if (samp) begin
      win_en_p0 <= {win_en_p0[DB_LEN-2:0], sync_en_p1};
      win_sp_p0 <= {win_sp_p0[DB_LEN-2:0], sync_sp_p1};
    end
  end

  // Stage: debounced levels plus their previous-cycle copies
  always_ff @(posedge clk) begin
    if (rst) begin
      db_en_p1 <= 1'b0;
      db_sp_p1 <= 1'b0;
      db_en_p2 <= 1'b0;
      db_sp_p2 <= 1'b0;
    end else begin
      db_en_p1 <= db_level(win_en_p0, db_en_p1);
      db_sp_p1 <= db_level(win_sp_p0, db_sp_p1);
      db_en_p2 <= db_en_p1;
      db_sp_p2 <= db_sp_p1;
    end
  end

  // A press is the single cycle where the level is new at 1; holding the
  // button keeps the level at 1 and so cannot produce a second press.
  assign press_en    = db_en_p1 & ~db_en_p2;
  assign press_speed = db_sp_p1 & ~db_sp_p2;

  // Stage: toggle latches
  always_ff @(posedge clk) begin
    if (rst) begin
      en    <= 1'b0;
      speed <= 1'b0;
    end else begin
      en    <= en ^ press_en;
      speed <= speed ^ press_speed;
    end
  end

  // Stage: tick counter; the slow wrap is also a fast wrap, so the two
  // strobes coincide every 2^(SLOW_W-FAST_W) fast strobes.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else
      cnt <= cnt + SLOW_W'(1);
  end

  assign f = &cnt[FAST_W-1:0];
  assign s = &cnt;

  // Stage: registered tick mux; speed is sampled together with f/s so a
  // speed change swaps streams without adding or dropping a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_1_p0 <= 1'b0;
      tick_3_p0 <= 1'b0;
    end else begin
      tick_1_p0 <= speed ? s : f;
      tick_3_p0 <= speed ? f : s;
    end
  end

`ifdef TICK_GATE_EN
  assign tick_1 = tick_1_p0 & en;
  assign tick_3 = tick_3_p0 & en;
`else
  assign tick_1 = tick_1_p0;
  assign tick_3 = tick_3_p0;
`endif

endmodule

// File: tb/tb_chaser_ctrl.sv
// Self-checking bench for chaser_ctrl with small parameters
// (DB_DIV=2, DB_LEN=3, FAST_W=3, SLOW_W=5). A behavioural model tracks
// the outputs from the button history: every 2^DB_DIV edges a sample of the
// button as seen two edges earlier is taken, a DB_LEN-sample window decides
// the debounced level, and a rising level toggles the latch two edges after
// the sample. Ticks follow from the edge count since reset.

module tb_chaser_ctrl;
  localparam int DB_DIV = 2;
  localparam int DB_LEN = 3;
  localparam int FAST_W = 3;
  localparam int SLOW_W = 5;
  localparam int SAMP_P = 1 << DB_DIV;
  localparam int FAST_P = 1 << FAST_W;
  localparam int SLOW_P = 1 << SLOW_W;
  localparam int HMAX   = 8192;
`ifdef TICK_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_en = 1'b0;
  logic btn_speed = 1'b0;
  logic en, speed, tick_1, tick_3;

  always #5 clk = ~clk;

  chaser_ctrl #(
    .DB_DIV(DB_DIV), .DB_LEN(DB_LEN), .FAST_W(FAST_W), .SLOW_W(SLOW_W)
  ) dut (
    .clk(clk), .rst(rst), .btn_en(btn_en), .btn_speed(btn_speed),
    .en(en), .speed(speed), .tick_1(tick_1), .tick_3(tick_3)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  int e = 0;
  bit hist_en [0:HMAX-1];
  bit hist_sp [0:HMAX-1];
  bit m_en, m_speed, m_t1, m_t3, lvl_en, lvl_sp;

  function automatic bit samp_of(input bit which, input int j);
    if (j < 1) return 1'b0;
    return which ? hist_sp[SAMP_P*j-2] : hist_en[SAMP_P*j-2];
  endfunction

  function automatic bit next_lvl(input bit which, input int k, input bit cur);
    int ones = 0;
    for (int i = 0; i < DB_LEN; i++) ones += int'(samp_of(which, k - i));
    if (ones == DB_LEN) return 1'b1;
    if (ones == 0) return 1'b0;
    return cur;
  endfunction

  task automatic model_edge(input bit be, input bit bs, input bit r);
    bit fast, slow, r1, r3, nl;
    int k;
    if (r) begin
      e = 0; m_en = 0; m_speed = 0; m_t1 = 0; m_t3 = 0; lvl_en = 0; lvl_sp = 0;
    end else begin
      e++;
      if (e >= HMAX) begin
        $display("FAIL model_range e=%0d limit=%0d", e, HMAX);
        $fatal(1);
      end
      hist_en[e] = be;
      hist_sp[e] = bs;
      fast = (e % FAST_P) == 0;
      slow = (e % SLOW_P) == 0;
      r1 = m_speed ? slow : fast;
      r3 = m_speed ? fast : slow;
      if (e >= SAMP_P + 2 && ((e - 2) % SAMP_P) == 0) begin
        k = (e - 2) / SAMP_P;
        nl = next_lvl(1'b0, k, lvl_en);
        if (nl && !lvl_en) m_en = ~m_en;
        lvl_en = nl;
        nl = next_lvl(1'b1, k, lvl_sp);
        if (nl && !lvl_sp) m_speed = ~m_speed;
        lvl_sp = nl;
      end
      m_t1 = r1 & (GATE ? m_en : 1'b1);
      m_t3 = r3 & (GATE ? m_en : 1'b1);
    end
  endtask

  // Drive inputs mid-cycle, advance one clock, update model, settle.
  task automatic step(input bit be, input bit bs, input bit r);
    @(negedge clk);
    btn_en = be; btn_speed = bs; rst = r;
    @(posedge clk);
    model_edge(be, bs, r);
    #1;
  endtask

  task automatic test_reset;
    int c1 = 0, c3 = 0, cc = 0;
    step(0, 0, 1);
    step(0, 0, 1);
    n_total++;
    if ({en, speed, tick_1, tick_3} !== 4'b0000) $display("FAIL reset_state got=%b required=0000", {en, speed, tick_1, tick_3});
    else n_pass++;
    for (int i = 0; i < 200; i++) begin
      step(0, 0, 0);
      n_total++;
      if ({en, speed, tick_1, tick_3} !== {m_en, m_speed, m_t1, m_t3})
        $display("FAIL idle_cycle e=%0d got=%b required=%b", e, {en, speed, tick_1, tick_3}, {m_en, m_speed, m_t1, m_t3});
      else n_pass++;
      if (e == 8) begin
        n_total++;
        if (tick_1 !== 1'b1) $display("FAIL first_tick_1 e=8 got=%b required=1", tick_1);
        else n_pass++;
      end
      c1 += int'(tick_1);
      c3 += int'(tick_3);
      cc += int'(tick_1 & tick_3);
    end
    n_total++;
    if (c1 !== 200 / FAST_P) $display("FAIL idle_tick_1_count got=%0d required=%0d", c1, 200 / FAST_P);
    else n_pass++;
    n_total++;
    if (c3 !== 200 / SLOW_P) $display("FAIL idle_tick_3_count got=%0d required=%0d", c3, 200 / SLOW_P);
    else n_pass++;
    n_total++;
    if (cc !== 200 / SLOW_P) $display("FAIL idle_coincident_count got=%0d required=%0d", cc, 200 / SLOW_P);
    else n_pass++;
  endtask

  task automatic test_en_press;
    int e_a = 0, rise_e = 0, rises = 0;
    bit prev;
    step(0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    prev = en;
    for (int i = 0; i < 140; i++) begin
      step(i < 100, 0, 0);
      if (i == 0) e_a = e;
      n_total++;
      if ({en, speed, tick_1, tick_3} !== {m_en, m_speed, m_t1, m_t3})
        $display("FAIL en_press_cycle e=%0d got=%b required=%b", e, {en, speed, tick_1, tick_3}, {m_en, m_speed, m_t1, m_t3});
      else n_pass++;
      if (en && !prev) begin rises++; rise_e = e; end
      prev = en;
    end
    n_total++;
    if (rises !== 1) $display("FAIL en_rise_count got=%0d required=1", rises);
    else n_pass++;
    n_total++;
    if (rise_e - e_a < 12 || rise_e - e_a > 20) $display("FAIL en_latency got=%0d required=12..20", rise_e - e_a);
    else n_pass++;
    n_total++;
    if (en !== 1'b1) $display("FAIL en_stays_high got=%b required=1", en);
    else n_pass++;
  endtask

  task automatic test_speed_bounce;
    int changes = 0, last1 = -1, last3 = -1, nd = 0;
    bit prev, v;
    step(0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    prev = speed;
    for (int i = 0; i < 12 + 40 + 30; i++) begin
      v = (i < 12) ? (((i / 3) % 2) == 0) : (i < 52);
      step(0, v, 0);
      n_total++;
      if ({en, speed, tick_1, tick_3} !== {m_en, m_speed, m_t1, m_t3})
        $display("FAIL speed_bounce_cycle e=%0d got=%b required=%b", e, {en, speed, tick_1, tick_3}, {m_en, m_speed, m_t1, m_t3});
      else n_pass++;
      if (speed !== prev) changes++;
      prev = speed;
      if (i == 11) begin
        n_total++;
        if (changes !== 0) $display("FAIL speed_no_toggle_on_bounce got=%0d required=0", changes);
        else n_pass++;
      end
    end
    n_total++;
    if (changes !== 1) $display("FAIL speed_toggle_count got=%0d required=1", changes);
    else n_pass++;
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0);
      if (tick_1) begin
        if (last1 >= 0) begin
          nd++;
          n_total++;
          if (e - last1 !== SLOW_P) $display("FAIL fast_speed_tick_1_period got=%0d required=%0d", e - last1, SLOW_P);
          else n_pass++;
        end
        last1 = e;
      end
      if (tick_3) begin
        if (last3 >= 0) begin
          n_total++;
          if (e - last3 !== FAST_P) $display("FAIL fast_speed_tick_3_period got=%0d required=%0d", e - last3, FAST_P);
          else n_pass++;
        end
        last3 = e;
      end
    end
    n_total++;
    if (nd < 1) $display("FAIL tick_1_period_seen got=%0d required>=1", nd);
    else n_pass++;
  endtask

  task automatic test_simultaneous;
    int e_en = -1, e_sp = -1;
    bit pe, ps;
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    pe = en; ps = speed;
    for (int i = 0; i < 70; i++) begin
      step(i < 40, i < 40, 0);
      n_total++;
      if ({en, speed, tick_1, tick_3} !== {m_en, m_speed, m_t1, m_t3})
        $display("FAIL simul_cycle e=%0d got=%b required=%b", e, {en, speed, tick_1, tick_3}, {m_en, m_speed, m_t1, m_t3});
      else n_pass++;
      if (en !== pe && e_en < 0) e_en = e;
      if (speed !== ps && e_sp < 0) e_sp = e;
      pe = en; ps = speed;
    end
    n_total++;
    if (e_en < 0 || e_en !== e_sp) $display("FAIL simul_same_edge en_edge=%0d speed_edge=%0d required equal", e_en, e_sp);
    else n_pass++;
  endtask

  task automatic test_reset_mid_hold;
    step(0, 0, 1);
    for (int i = 0; i < 40; i++) step(1, 0, 0);
    n_total++;
    if (en !== 1'b1) $display("FAIL hold_before_reset en got=%b required=1", en);
    else n_pass++;
    step(1, 0, 1);
    n_total++;
    if ({en, tick_1, tick_3} !== 3'b000) $display("FAIL mid_hold_reset got=%b required=000", {en, tick_1, tick_3});
    else n_pass++;
    for (int i = 0; i < 60; i++) begin
      step(i < 40, 0, 0);
      n_total++;
      if ({en, speed, tick_1, tick_3} !== {m_en, m_speed, m_t1, m_t3})
        $display("FAIL reset_hold_cycle e=%0d got=%b required=%b", e, {en, speed, tick_1, tick_3}, {m_en, m_speed, m_t1, m_t3});
      else n_pass++;
    end
    n_total++;
    if (en !== 1'b1) $display("FAIL en_after_reset_hold got=%b required=1", en);
    else n_pass++;
  endtask

  task automatic test_random;
    bit be = 0, bs = 0;
    int run = 0;
    step(0, 0, 1);
    for (int i = 0; i < 800; i++) begin
      if (run == 0) begin
        be = $urandom_range(1, 0) == 1;
        bs = $urandom_range(1, 0) == 1;
        run = $urandom_range(24, 1);
      end
      run--;
      step(be, bs, 0);
      n_total++;
      if ({en, speed, tick_1, tick_3} !== {m_en, m_speed, m_t1, m_t3})
        $display("FAIL random_cycle e=%0d got=%b required=%b", e, {en, speed, tick_1, tick_3}, {m_en, m_speed, m_t1, m_t3});
      else n_pass++;
    end
  endtask

`ifdef TICK_GATE_EN
  task automatic test_gate;
    int first = -1;
    step(0, 0, 1);
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 0);
      n_total++;
      if ({tick_1, tick_3} !== 2'b00) $display("FAIL gate_paused e=%0d got=%b required=00", e, {tick_1, tick_3});
      else n_pass++;
    end
    for (int i = 0; i < 60; i++) begin
      step(i < 30, 0, 0);
      n_total++;
      if ({en, speed, tick_1, tick_3} !== {m_en, m_speed, m_t1, m_t3})
        $display("FAIL gate_cycle e=%0d got=%b required=%b", e, {en, speed, tick_1, tick_3}, {m_en, m_speed, m_t1, m_t3});
      else n_pass++;
      if (tick_1 && first < 0) first = e;
    end
    n_total++;
    if (first < 0 || (first % FAST_P) != 0) $display("FAIL gate_resume_grid first_tick_edge=%0d required multiple of %0d", first, FAST_P);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_en_press();
    test_speed_bounce();
    test_simultaneous();
    test_reset_mid_hold();
    test_random();
`ifdef TICK_GATE_EN
    test_gate();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
